n_adder: RTL and testbench
==========================

Name: n_adder

Overview:
- Parameterised WIDTH-bit binary adder with carry-in and carry-out.
- Structured as a ripple-carry chain of 1-bit full-adder cells.
- Outputs S and Cout are registered on the single system clock.
- Used as the generic N-bit adder primitive; WIDTH=8 is the standard build.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1..64.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- A  input  WIDTH  operand A, unsigned.
- B  input  WIDTH  operand B, unsigned.
- Cin  input  1  carry-in, weight 1.
- S  output  WIDTH  registered sum, low WIDTH bits of A+B+Cin.
- Cout  output  1  registered carry-out, bit WIDTH of A+B+Cin.

Behaviour:
- Arithmetic: {Cout,S} = A + B + Cin, computed at WIDTH+1 bits; unsigned; no saturation.
- Structure: WIDTH full-adder cells built with a generate loop.
  - Cell i: s_i = a_i ^ b_i ^ c_i; c_(i+1) = a_i&b_i | a_i&c_i | b_i&c_i.
  - c_0 = Cin; Cout = c_WIDTH.
  - Behavioural "+" is not used for the sum path.
- Timing: A, B and Cin are sampled on every rising clk. S and Cout reflect the sampled operands after that same edge (latency 1 cycle).
- Throughput: one new operation per cycle. There is no handshake and no enable; outputs update every cycle.
- Reset: while rst=1, S=0 and Cout=0 immediately, without waiting for a clock edge; asserting rst mid-operation discards any result.
- Reset release: the first rising clk with rst=0 loads the result for the current inputs.
- Wrap-around: a sum of 2^WIDTH or more sets Cout=1 and S = sum - 2^WIDTH.
- Maximum case: A = B = all ones with Cin=1 gives S = all ones, Cout=1.
- Zero case: A = B = 0 with Cin=0 gives S=0, Cout=0.
- X/Z on inputs propagates to the outputs; no masking.
- WIDTH=1: the block degenerates to a registered single full adder.

Test Plan (WIDTH=8):
- Reset: assert rst asynchronously between edges -> S=0, Cout=0 immediately; outputs hold 0 across clk edges while rst=1.
- No carry: A=5, B=250, Cin=0 -> after one edge S=255, Cout=0. Also A=0, B=250, Cin=0 -> S=250, Cout=0.
- Carry-in causes wrap: A=5, B=250, Cin=1 -> S=0, Cout=1. Also A=9, B=250, Cin=1 -> S=4, Cout=1.
- Sweep: A=0..9 with B=250, Cin∈{0,1}, one operand set per cycle.
  - Each result appears exactly one edge later.
  - Cout=1 exactly when A+Cin ≥ 6; e.g. A=9, Cin=0 -> S=3, Cout=1.
- Extremes and full ripple:
  - A=255, B=255, Cin=1 -> S=255, Cout=1.
  - A=255, B=0, Cin=1 -> S=0, Cout=1 (carry ripples the full chain).
- Random: 1000 random A/B/Cin triples compared against a (WIDTH+1)-bit reference sum delayed by one cycle; repeat with WIDTH=1 and WIDTH=32.

Source files
------------

// File: rtl/n_adder_if.sv
// Operand and result bundle for the registered ripple-carry adder.
interface n_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic [WIDTH-1:0] S;
    logic             Cout;

    modport master (
        output A,
        output B,
        output Cin,
        input  S,
        input  Cout
    );

    modport slave (
        input  A,
        input  B,
        input  Cin,
        output S,
        output Cout
    );
endinterface

// File: rtl/n_adder.sv
// WIDTH-bit ripple-carry adder built from full-adder cells; sum and
// carry-out are registered on clk and cleared asynchronously by rst.
module n_adder #(
    parameter int unsigned WIDTH = 8
) (
    input logic       clk,
    input logic       rst,
    n_adder_if.slave  bus
);
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    assign c[0] = bus.Cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign s[i]   = bus.A[i] ^ bus.B[i] ^ c[i];
        assign c[i+1] = (bus.A[i] & bus.B[i]) | (bus.A[i] & c[i]) | (bus.B[i] & c[i]);
    end

    // Register the ripple result every cycle; reset clears outputs at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.S    <= '0;
            bus.Cout <= 1'b0;
        end else begin
            bus.S    <= s;
            bus.Cout <= c[WIDTH];
        end
    end
endmodule

// File: tb/tb_n_adder.sv
// Scoreboard bench for n_adder at WIDTH 8, 1 and 32 driven in parallel.
module tb_n_adder;
    logic clk = 1'b0;
    logic rst = 1'b0;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [64:0] q8[$];
    logic [64:0] q1[$];
    logic [64:0] q32[$];

    n_adder_if #(.WIDTH(8))  bus8 ();
    n_adder_if #(.WIDTH(1))  bus1 ();
    n_adder_if #(.WIDTH(32)) bus32 ();

    n_adder #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
    n_adder #(.WIDTH(1))  dut1  (.clk(clk), .rst(rst), .bus(bus1));
    n_adder #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [64:0] ref_sum(input int unsigned w, input logic [31:0] a,
                                            input logic [31:0] b, input logic cin);
        logic [64:0] mask;
        mask = (65'd1 << w) - 65'd1;
        return ({33'd0, a} & mask) + ({33'd0, b} & mask) + {64'd0, cin};
    endfunction

    function automatic logic [64:0] out8();
        return {56'd0, bus8.Cout, bus8.S};
    endfunction
    function automatic logic [64:0] out1();
        return {63'd0, bus1.Cout, bus1.S};
    endfunction
    function automatic logic [64:0] out32();
        return {32'd0, bus32.Cout, bus32.S};
    endfunction

    task automatic compare_pending();
        if (q8.size() > 0)  check("w8",  out8(),  q8.pop_front());
        if (q1.size() > 0)  check("w1",  out1(),  q1.pop_front());
        if (q32.size() > 0) check("w32", out32(), q32.pop_front());
    endtask

    task automatic push_expected(input logic [31:0] a, input logic [31:0] b, input logic cin);
        q8.push_back(ref_sum(8, a, b, cin));
        q1.push_back(ref_sum(1, a, b, cin));
        q32.push_back(ref_sum(32, a, b, cin));
    endtask

    // One operation per cycle: check last result, then present new operands.
    task automatic cycle(input logic [31:0] a, input logic [31:0] b, input logic cin);
        @(negedge clk);
        compare_pending();
        bus8.A   = a[7:0];  bus8.B  = b[7:0];  bus8.Cin  = cin;
        bus1.A   = a[0];    bus1.B  = b[0];    bus1.Cin  = cin;
        bus32.A  = a;       bus32.B = b;       bus32.Cin = cin;
        push_expected(a, b, cin);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_w8"},  out8(),  65'd0);
        check({tag, "_w1"},  out1(),  65'd0);
        check({tag, "_w32"}, out32(), 65'd0);
    endtask

    initial begin
        bus8.A = '0;  bus8.B = '0;  bus8.Cin = 1'b0;
        bus1.A = '0;  bus1.B = '0;  bus1.Cin = 1'b0;
        bus32.A = '0; bus32.B = '0; bus32.Cin = 1'b0;

        // Asynchronous reset before any clock edge, then held across edges.
        #2 rst = 1'b1;
        #1 check_zero("rst_async");
        bus8.A = 8'd5; bus8.B = 8'd250; bus8.Cin = 1'b1;
        bus32.A = 32'd5; bus32.B = 32'd250; bus32.Cin = 1'b1;
        bus1.A = 1'b1; bus1.B = 1'b0; bus1.Cin = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_zero("rst_hold");
        end
        rst = 1'b0;
        push_expected(32'd5, 32'd250, 1'b1);

        // Directed cases
        cycle(32'd5,   32'd250, 1'b0);
        cycle(32'd0,   32'd250, 1'b0);
        cycle(32'd5,   32'd250, 1'b1);
        cycle(32'd9,   32'd250, 1'b1);
        cycle(32'd255, 32'd255, 1'b1);
        cycle(32'd255, 32'd0,   1'b1);
        cycle(32'd0,   32'd0,   1'b0);
        cycle(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        cycle(32'hFFFF_FFFF, 32'd0, 1'b1);

        // Sweep A=0..9 with B=250 and both carry-in values
        for (int unsigned a = 0; a < 10; a++) begin
            for (int unsigned ci = 0; ci < 2; ci++) begin
                cycle(a, 32'd250, ci[0]);
            end
        end

        // Reset mid-operation discards the in-flight result
        cycle(32'd5, 32'd250, 1'b0);
        cycle(32'd9, 32'd250, 1'b1);
        #2 rst = 1'b1;
        #1 check_zero("rst_mid");
        q8.delete(); q1.delete(); q32.delete();
        repeat (2) begin
            @(negedge clk);
            check_zero("rst_mid_hold");
        end
        rst = 1'b0;
        push_expected(32'd9, 32'd250, 1'b1);

        // Random operands
        for (int unsigned n = 0; n < 1000; n++) begin
            cycle($urandom, $urandom, $urandom_range(1, 0) == 1);
        end
        @(negedge clk);
        compare_pending();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
